// File: rtl/mem2_load_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem2_load_stage
// Description : Second memory pipeline stage. Holds one instruction between
//               MEM and WB, waits for the dcache read response of a load,
//               buffers an early response when the stage cannot advance,
//               discards responses that belong to flushed loads, and aligns
//               and extends the returned word for LB/LBU/LH/LHU/LW.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               mem2_wr, mem2_flush - hazard-unit advance / bubble controls
//               mem_*               - instruction bundle from the MEM stage
//               dcache_rvalid/rdata - dcache read response (1-cycle pulse)
//               mem2_stall          - held load still waiting for data
//               wb_*                - writeback bundle, wb_commit = retire
//               fwd_valid           - wb_dst/wb_data may be bypassed
// Revision    : 1.0 - initial release
// ============================================================================
module mem2_load_stage #(
    parameter int DROP_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem2_wr,
    input  logic        mem2_flush,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_result,
    input  logic [4:0]  mem_dst,
    input  logic        mem_reg_wr,
    input  logic [2:0]  mem_load_type,
    input  logic        mem_dreq,
    input  logic        dcache_rvalid,
    input  logic [31:0] dcache_rdata,
    output logic        mem2_stall,
    output logic        wb_commit,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_dst,
    output logic        wb_wen,
    output logic [31:0] wb_data,
    output logic        fwd_valid
);

    localparam logic [2:0]        c_lt_lb    = 3'd1;
    localparam logic [2:0]        c_lt_lbu   = 3'd2;
    localparam logic [2:0]        c_lt_lh    = 3'd3;
    localparam logic [2:0]        c_lt_lhu   = 3'd4;
    localparam logic [DROP_W-1:0] c_drop_max = '1;

    // Stage register
    logic              r_valid;
    logic [31:0]       r_pc;
    logic [1:0]        r_addr;
    logic [31:0]       r_result;
    logic [4:0]        r_dst;
    logic              r_reg_wr;
    logic [2:0]        r_load_type;
    logic              r_is_load;
    logic              r_buf_valid;
    logic [31:0]       r_buf_data;
    logic [DROP_W-1:0] r_drop_cnt;

    logic        w_drop_zero;
    logic        w_complete;
    logic        w_stall;
    logic        w_advance;
    logic        w_wait;
    logic        w_buf_capture;
    logic        w_drop_inc;
    logic        w_drop_dec;
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // A response is ours only when no flushed load is still owed one.
    assign w_drop_zero   = (r_drop_cnt == '0);
    assign w_complete    = !r_is_load || r_buf_valid || (dcache_rvalid && w_drop_zero);
    assign w_wait        = r_valid && r_is_load && !r_buf_valid;
    assign w_stall       = r_valid && r_is_load && !w_complete;
    assign w_advance     = mem2_wr && !w_stall;
    assign w_buf_capture = w_wait && dcache_rvalid && w_drop_zero && !w_advance;
    assign w_drop_inc    = w_advance && mem2_flush && mem_valid && mem_dreq;
    assign w_drop_dec    = dcache_rvalid && !w_drop_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_addr      <= '0;
            r_result    <= '0;
            r_dst       <= '0;
            r_reg_wr    <= 1'b0;
            r_load_type <= '0;
            r_is_load   <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_advance) begin
                if (mem2_flush) begin
                    r_valid     <= 1'b0;
                    r_pc        <= '0;
                    r_addr      <= '0;
                    r_result    <= '0;
                    r_dst       <= '0;
                    r_reg_wr    <= 1'b0;
                    r_load_type <= '0;
                    r_is_load   <= 1'b0;
                end else begin
                    r_valid     <= mem_valid;
                    r_pc        <= mem_pc;
                    r_addr      <= mem_addr[1:0];
                    r_result    <= mem_result;
                    r_dst       <= mem_dst;
                    r_reg_wr    <= mem_reg_wr;
                    r_load_type <= mem_load_type;
                    r_is_load   <= mem_dreq && (mem_load_type != 3'd0);
                end
                r_buf_valid <= 1'b0;
                r_buf_data  <= '0;
            end else if (w_buf_capture) begin
                r_buf_valid <= 1'b1;
                r_buf_data  <= dcache_rdata;
            end

            // Simultaneous increment and decrement cancel out.
            if (w_drop_inc && !w_drop_dec) begin
                if (r_drop_cnt != c_drop_max) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end else if (w_drop_dec && !w_drop_inc) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    // Load alignment and extension
    assign w_raw  = r_buf_valid ? r_buf_data : dcache_rdata;
    assign w_half = r_addr[1] ? w_raw[31:16] : w_raw[15:0];

    always_comb begin
        w_byte = w_raw[7:0];
        case (r_addr)
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            2'd3:    w_byte = w_raw[31:24];
            default: w_byte = w_raw[7:0];
        endcase
    end

    always_comb begin
        w_load_data = w_raw;
        case (r_load_type)
            c_lt_lb:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_lt_lbu: w_load_data = {24'd0, w_byte};
            c_lt_lh:  w_load_data = {{16{w_half[15]}}, w_half};
            c_lt_lhu: w_load_data = {16'd0, w_half};
            default:  w_load_data = w_raw;
        endcase
    end

    // Outputs are forced low while reset is asserted so that the stage
    // reads as empty even before the first reset edge.
    assign mem2_stall = !rst && w_stall;
    assign wb_commit  = !rst && w_advance && r_valid;
    assign wb_pc      = rst ? 32'd0 : r_pc;
    assign wb_dst     = rst ? 5'd0  : r_dst;
    assign wb_data    = rst ? 32'd0 : (r_is_load ? w_load_data : r_result);
    assign wb_wen     = !rst && r_valid && r_reg_wr && w_complete;
    assign fwd_valid  = !rst && r_valid && r_reg_wr && w_complete;

endmodule
`default_nettype wire

// File: doc/mem2_load_stage.md
MEM2_LOAD_STAGE -- requirements
Module: mem2_load_stage

Interface
REQ-001 SHALL have parameter DROP_W, default 2: width of the discarded-response counter.
REQ-002 SHALL have clk  in  1: sole clock, all state updates on its rising edge.
REQ-003 SHALL have rst  in  1: synchronous, active-high reset.
REQ-004 SHALL have mem2_wr  in  1: stage write enable from the hazard unit.
REQ-005 SHALL have mem2_flush  in  1: load a bubble instead of the MEM instruction at advance.
REQ-006 SHALL have mem_valid  in  1: the MEM stage holds a real instruction.
REQ-007 SHALL have mem_pc  in  32: PC of the MEM instruction.
REQ-008 SHALL have mem_addr  in  32: MEM ALU output, which is the load address.
REQ-009 SHALL have mem_result  in  32: writeback data for a non-load instruction.
REQ-010 SHALL have mem_dst  in  5: destination register number.
REQ-011 SHALL have mem_reg_wr  in  1: the instruction writes the GPR file.
REQ-012 SHALL have mem_load_type  in  3: load code, 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6 and 7 are treated as LW.
REQ-013 SHALL have mem_dreq  in  1: a dcache read request was issued in MEM for this load.
REQ-014 SHALL have dcache_rvalid  in  1: one-cycle pulse indicating the dcache read response is valid.
REQ-015 SHALL have dcache_rdata  in  32: the aligned 32-bit word returned by the dcache.
REQ-016 SHALL have mem2_stall  out  1: the held load has not yet received its data.
REQ-017 SHALL have wb_commit  out  1: the held instruction retires this cycle.
REQ-018 SHALL have wb_pc  out  32, wb_dst  out  5, wb_wen  out  1, wb_data  out  32: writeback bundle.
REQ-019 SHALL have fwd_valid  out  1: wb_dst and wb_data are final and can be bypassed.

Function
REQ-020 SHALL hold a one-entry stage register S containing: valid, pc, addr[1:0], result, dst, reg_wr, load_type, is_load (= mem_dreq & load_type!=0), plus buf_valid and buf_data.
REQ-021 SHALL derive the stage state as EMPTY (!S.valid), WAIT (S.valid & is_load & !complete) or READY (all other cases).
REQ-022 SHALL compute complete = !is_load | buf_valid | (dcache_rvalid & drop_cnt==0).
REQ-023 SHALL drive mem2_stall = S.valid & is_load & !complete, combinationally, with zero latency from dcache_rvalid.
REQ-024 SHALL define advance = mem2_wr & !mem2_stall; S SHALL change only on advance, apart from the buffer capture in REQ-027.
REQ-025 On advance with mem2_flush=0, S SHALL capture the MEM inputs, with valid=mem_valid and buf_valid=0.
REQ-026 On advance with mem2_flush=1, S SHALL become a bubble (valid=0); mem2_flush SHALL be ignored when there is no advance.
REQ-027 In WAIT with dcache_rvalid, drop_cnt==0 and no advance, the block SHALL set buf_valid=1 and buf_data=dcache_rdata.
REQ-028 When dcache_rvalid and drop_cnt>0, the block SHALL discard the response and decrement drop_cnt.
REQ-029 On advance with mem2_flush=1, mem_valid=1 and mem_dreq=1, the block SHALL increment drop_cnt.
REQ-030 When an increment and a decrement of drop_cnt occur in the same cycle, drop_cnt SHALL stay unchanged; drop_cnt SHALL saturate at 2^DROP_W-1.
REQ-031 A dcache_rvalid arriving with drop_cnt==0 while the stage is not in WAIT SHALL be discarded with no state change.
REQ-032 SHALL drive wb_commit = advance & S.valid; each instruction SHALL commit exactly once.
REQ-033 SHALL select the raw load word as buf_data when buf_valid=1, otherwise dcache_rdata.
REQ-034 LB/LBU SHALL use byte addr[1:0], sign-extended for LB and zero-extended for LBU.
REQ-035 LH/LHU SHALL use halfword addr[1], ignoring addr[0], sign-extended for LH and zero-extended for LHU; LW SHALL pass the word unchanged.
REQ-036 wb_data SHALL be the aligned load data for a load, otherwise S.result; wb_pc=S.pc, wb_dst=S.dst, wb_wen=S.valid & S.reg_wr & complete.
REQ-037 SHALL drive fwd_valid = S.valid & S.reg_wr & complete.

Reset
REQ-038 When rst=1 at a clock edge, the block SHALL clear S.valid, buf_valid and drop_cnt to 0 and enter EMPTY, overriding every other input.
REQ-039 During and immediately after reset, every output SHALL read 0, including mem2_stall=0 and wb_commit=0.
REQ-040 The block SHALL also clear stored S data fields to 0 on reset.
REQ-041 A dcache_rvalid in the cycle rst is asserted SHALL be lost.

Verification
REQ-042 Non-load ADDU with result 0x1234 and dst 5 -> next cycle wb_wen=1, wb_data=0x00001234, and wb_commit=1 in the following advance cycle.
REQ-043 LB at addr 0x...2 with rdata 0x11_80_33_44 arriving after 3 stall cycles -> mem2_stall=1 for 3 cycles, then wb_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-044 Data arrives while mem2_wr=0 for 2 cycles -> buffer holds 0xCAFEBABE, mem2_stall=0, then a single commit with wb_data=0xCAFEBABE.
REQ-045 Flushed load with mem_dreq=1, followed by an LW -> first rvalid 0xDEAD0000 discarded, drop_cnt returns to 0, LW retires with the second rvalid 0x00C0FFEE.
REQ-046 rst asserted in WAIT with drop_cnt=1 -> next cycle all outputs 0 and state EMPTY; a following rvalid causes no change.
